// File: rtl/vec_sram_arb_if.sv
//------------------------------------------------------------------------------
// Module      : vec_sram_arb_if
// Description : Host (valid/ready), engine (req/gnt) and SRAM bus signals
//               shared by the vector SRAM arbiter and its neighbours.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface vec_sram_arb_if #(
    parameter int SRAM_ADDR_WIDTH = 10,
    parameter int DATA_WIDTH      = 8
);
    logic                       h_valid;
    logic                       h_ready;
    logic                       h_we;
    logic [SRAM_ADDR_WIDTH-1:0] h_addr;
    logic [DATA_WIDTH-1:0]      h_din;
    logic                       h_rvalid;
    logic [DATA_WIDTH-1:0]      h_rdata;

    logic                       mm_req;
    logic                       mm_gnt;
    logic                       mm_we;
    logic [SRAM_ADDR_WIDTH-1:0] mm_addr;
    logic [DATA_WIDTH-1:0]      mm_din;
    logic                       mm_rvalid;
    logic [DATA_WIDTH-1:0]      mm_rdata;

    logic                       sram_we;
    logic [SRAM_ADDR_WIDTH-1:0] sram_addr;
    logic [DATA_WIDTH-1:0]      sram_din;
    logic [DATA_WIDTH-1:0]      sram_dout;

    // Arbiter side
    modport slave (
        input  h_valid, h_we, h_addr, h_din,
        output h_ready, h_rvalid, h_rdata,
        input  mm_req, mm_we, mm_addr, mm_din,
        output mm_gnt, mm_rvalid, mm_rdata,
        output sram_we, sram_addr, sram_din,
        input  sram_dout
    );

    // Requester / memory side
    modport master (
        output h_valid, h_we, h_addr, h_din,
        input  h_ready, h_rvalid, h_rdata,
        output mm_req, mm_we, mm_addr, mm_din,
        input  mm_gnt, mm_rvalid, mm_rdata,
        input  sram_we, sram_addr, sram_din,
        output sram_dout
    );
endinterface

`default_nettype wire

// File: rtl/vec_sram_arb.sv
//------------------------------------------------------------------------------
// Module      : vec_sram_arb
// Description : Single-port vector SRAM arbiter, engine priority with a
//               bounded host stall, 1-cycle read data steering.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module vec_sram_arb #(
    parameter int SRAM_ADDR_WIDTH = 10,
    parameter int DATA_WIDTH      = 8,
    parameter int MAX_STALL       = 3
) (
    input  wire logic     clk,
    input  wire logic     rst,
    vec_sram_arb_if.slave bus
);

    // A zero-width counter is not legal, so MAX_STALL=0 keeps one idle bit
    localparam int                 c_cnt_w     = (MAX_STALL > 0) ? $clog2(MAX_STALL + 1) : 1;
    localparam logic [c_cnt_w-1:0] c_max_stall = c_cnt_w'(MAX_STALL);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_HOST = 2'd1,
        OWN_MM   = 2'd2
    } owner_t;

    owner_t                     w_owner;
    logic                       w_we;
    logic [SRAM_ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0]      w_din;

    owner_t                     r_rd_owner;
    logic [c_cnt_w-1:0]         r_stall_cnt;

    always_comb begin
        w_owner = OWN_NONE;
        if (!rst) begin
            if (bus.h_valid && (!bus.mm_req || (r_stall_cnt == c_max_stall))) begin
                w_owner = OWN_HOST;
            end else if (bus.mm_req) begin
                w_owner = OWN_MM;
            end
        end
    end

    // Idle cycles park the engine's address/data on the bus with writes off
    always_comb begin
        w_addr = bus.mm_addr;
        w_din  = bus.mm_din;
        w_we   = 1'b0;
        case (w_owner)
            OWN_HOST: begin
                w_addr = bus.h_addr;
                w_din  = bus.h_din;
                w_we   = bus.h_we;
            end
            OWN_MM: begin
                w_we   = bus.mm_we;
            end
            default: begin
                w_we   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_owner  <= OWN_NONE;
            r_stall_cnt <= '0;
        end else begin
            r_rd_owner <= ((w_owner != OWN_NONE) && !w_we) ? w_owner : OWN_NONE;

            if (!bus.h_valid || (w_owner == OWN_HOST)) begin
                r_stall_cnt <= '0;
            end else if (r_stall_cnt != c_max_stall) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign bus.h_ready   = (w_owner == OWN_HOST);
    assign bus.mm_gnt    = (w_owner == OWN_MM);

    assign bus.sram_we   = w_we;
    assign bus.sram_addr = w_addr;
    assign bus.sram_din  = w_din;

    // Read data is broadcast; only the rvalid strobes tell the requesters apart
    assign bus.h_rvalid  = (r_rd_owner == OWN_HOST);
    assign bus.mm_rvalid = (r_rd_owner == OWN_MM);
    assign bus.h_rdata   = bus.sram_dout;
    assign bus.mm_rdata  = bus.sram_dout;

endmodule

`default_nettype wire

// File: tb/tb_vec_sram_arb.sv
//------------------------------------------------------------------------------
// Module      : tb_vec_sram_arb
// Description : Self-checking bench for vec_sram_arb with a behavioural
//               memory/arbitration reference model and random traffic.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_vec_sram_arb;

    localparam int AW = 10;
    localparam int DW = 8;
    localparam int MS = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vec_sram_arb_if #(.SRAM_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    vec_sram_arb_if #(.SRAM_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();

    vec_sram_arb #(.SRAM_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_STALL(MS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    vec_sram_arb #(.SRAM_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_STALL(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    // Single-port SRAM with one cycle of read latency
    logic [DW-1:0] sram_mem [2**AW];
    always @(posedge clk) begin
        if (bus.sram_we) sram_mem[bus.sram_addr] <= bus.sram_din;
        bus.sram_dout <= sram_mem[bus.sram_addr];
    end
    assign bus0.sram_dout = '0;

    // Reference model state
    logic [DW-1:0] ref_mem [2**AW];
    int            waited;      // consecutive cycles the host has been refused
    int            pend;        // 0 none, 1 host, 2 engine read due this cycle
    logic [DW-1:0] pend_data;
    bit            exp_h, exp_m;
    logic          obs_h, obs_m;
    int            n_pass = 0;
    int            n_checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic set_h(input bit v, input bit we, input int a, input int d);
        bus.h_valid = v;
        bus.h_we    = we;
        bus.h_addr  = AW'(a);
        bus.h_din   = DW'(d);
    endtask

    task automatic set_m(input bit v, input bit we, input int a, input int d);
        bus.mm_req  = v;
        bus.mm_we   = we;
        bus.mm_addr = AW'(a);
        bus.mm_din  = DW'(d);
    endtask

    // One clock cycle: inputs were applied at the preceding negedge
    task automatic tick();
        bit            gwe;
        logic [AW-1:0] ga;
        logic [DW-1:0] gd;
        #1;
        exp_h = !rst && bus.h_valid && (!bus.mm_req || waited >= MS);
        exp_m = !rst && !exp_h && bus.mm_req;
        obs_h = bus.h_ready;
        obs_m = bus.mm_gnt;
        check("grant", 32'({bus.h_ready, bus.mm_gnt}), 32'({exp_h, exp_m}));
        check("rvalid", 32'({bus.h_rvalid, bus.mm_rvalid}), 32'({pend == 1, pend == 2}));
        if (pend == 1) check("h_rdata", 32'(bus.h_rdata), 32'(pend_data));
        if (pend == 2) check("mm_rdata", 32'(bus.mm_rdata), 32'(pend_data));
        pend = 0;
        if (rst || !(exp_h || exp_m)) begin
            check("sram_we_idle", 32'(bus.sram_we), 32'd0);
        end else begin
            gwe = exp_h ? bus.h_we   : bus.mm_we;
            ga  = exp_h ? bus.h_addr : bus.mm_addr;
            gd  = exp_h ? bus.h_din  : bus.mm_din;
            check("sram_addr", 32'(bus.sram_addr), 32'(ga));
            check("sram_we", 32'(bus.sram_we), 32'(gwe));
            if (gwe) begin
                check("sram_din", 32'(bus.sram_din), 32'(gd));
                ref_mem[ga] = gd;
            end else begin
                pend      = exp_h ? 1 : 2;
                pend_data = ref_mem[ga];
            end
        end
        if (rst || !bus.h_valid || exp_h) waited = 0;
        else waited++;
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d;
        waited = 0;
        pend   = 0;
        set_h(0, 0, 0, 0);
        set_m(0, 0, 0, 0);
        bus0.h_valid = 0; bus0.h_we = 0; bus0.h_addr = '0; bus0.h_din = '0;
        bus0.mm_req  = 0; bus0.mm_we = 0; bus0.mm_addr = '0; bus0.mm_din = '0;

        // Reset: no grants and no writes even with both requesting
        @(negedge clk);
        @(negedge clk);
        set_h(1, 1, 7, 8'h3C);
        set_m(1, 1, 8, 8'h4D);
        tick();
        check("rst_h_rvalid", 32'(bus.h_rvalid), 32'd0);
        check("rst_mm_rvalid", 32'(bus.mm_rvalid), 32'd0);
        set_h(0, 0, 0, 0);
        set_m(0, 0, 0, 0);
        rst = 1'b0;

        // Preload addresses 0..15 through the engine port
        for (int i = 0; i < 16; i++) begin
            set_m(1, 1, i, $urandom_range(0, 255));
            tick();
        end
        set_m(0, 0, 0, 0);

        // Host only: write then read back
        set_h(1, 1, 5, 8'hA5);
        tick();
        check("host_wr_ready", 32'(obs_h), 32'd1);
        set_h(1, 0, 5, 0);
        tick();
        check("host_rd_ready", 32'(obs_h), 32'd1);
        check("host_rd_rvalid", 32'(bus.h_rvalid), 32'd1);
        check("host_rd_data", 32'(bus.h_rdata), 32'hA5);
        check("host_rd_mm_rvalid", 32'(bus.mm_rvalid), 32'd0);
        set_h(0, 0, 0, 0);
        tick();

        // Engine only: four pipelined reads of 10..13
        for (int i = 0; i < 4; i++) begin
            set_m(1, 1, i, 10 + i);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            set_m(1, 0, i, 0);
            tick();
            check("mm_b2b_gnt", 32'(obs_m), 32'd1);
            check("mm_b2b_rvalid", 32'(bus.mm_rvalid), 32'd1);
            check("mm_b2b_data", 32'(bus.mm_rdata), 32'(10 + i));
        end
        set_m(0, 0, 0, 0);
        tick();

        // Contention: host wins every fourth cycle
        for (int c = 0; c < 12; c++) begin
            set_h(1, 1, 100, 8'h55);
            set_m(1, 1, 101, 8'h66);
            tick();
            check("cont_host", 32'(obs_h), 32'((c % 4) == 3));
            check("cont_mm", 32'(obs_m), 32'((c % 4) != 3));
        end
        set_h(0, 0, 0, 0);
        set_m(0, 0, 0, 0);
        tick();

        // MAX_STALL=0 instance: host always wins
        bus0.h_valid = 1; bus0.mm_req = 1;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("ms0_h_ready", 32'(bus0.h_ready), 32'd1);
            check("ms0_mm_gnt", 32'(bus0.mm_gnt), 32'd0);
            @(negedge clk);
        end
        bus0.h_valid = 0;
        #1;
        check("ms0_mm_gnt_after", 32'(bus0.mm_gnt), 32'd1);
        @(negedge clk);
        bus0.mm_req = 0;

        // Interleaved read return
        set_m(1, 1, 1, 8'h11); tick();
        set_m(1, 1, 2, 8'h22); tick();
        set_m(0, 0, 0, 0);     tick();
        set_m(1, 0, 1, 0);
        tick();
        check("il_mm_rvalid", 32'(bus.mm_rvalid), 32'd1);
        check("il_mm_rdata", 32'(bus.mm_rdata), 32'h11);
        check("il_h_rvalid0", 32'(bus.h_rvalid), 32'd0);
        set_m(0, 0, 0, 0);
        set_h(1, 0, 2, 0);
        tick();
        check("il_h_rvalid", 32'(bus.h_rvalid), 32'd1);
        check("il_h_rdata", 32'(bus.h_rdata), 32'h22);
        check("il_mm_rvalid0", 32'(bus.mm_rvalid), 32'd0);
        set_h(0, 0, 0, 0);
        tick();

        // Reset while a host read is in flight
        set_h(1, 0, 3, 0);
        #1;
        check("rmr_ready", 32'(bus.h_ready), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rmr_h_rvalid", 32'(bus.h_rvalid), 32'd0);
        check("rmr_grants", 32'({bus.h_ready, bus.mm_gnt}), 32'd0);
        pend   = 0;
        waited = 0;
        @(negedge clk);
        set_m(1, 0, 4, 0);
        tick();
        rst = 1'b0;
        set_h(0, 0, 0, 0);
        set_m(0, 0, 0, 0);
        tick();
        check("rmr_after_rvalid", 32'(bus.h_rvalid), 32'd0);

        // Random traffic against the reference model
        exp_h = 0;
        exp_m = 0;
        for (int c = 0; c < 800; c++) begin
            if (!bus.h_valid || exp_h) begin
                d = DW'($urandom);
                set_h($urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1, $urandom_range(0, 15), d);
            end
            if (!bus.mm_req || exp_m) begin
                d = DW'($urandom);
                set_m($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, $urandom_range(0, 15), d);
            end
            tick();
        end
        set_h(0, 0, 0, 0);
        set_m(0, 0, 0, 0);
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
